// File: rtl/cfo_phase_sequencer_if.sv
// Bus between the CFO frame controller and its environment: estimator strobes,
// sample strobes in, and the rotation phase stream toward the CORDIC derotator out.
interface cfo_phase_sequencer_if #(
  parameter int CNT_W = 12
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic [15:0]      coarse_in;
  logic             coarse_rdy;
  logic [15:0]      fine_in;
  logic             fine_rdy;
  logic             smp_in_vld;
  logic [15:0]      rot_phase;
  logic             rot_phase_vld;
  logic             busy;
  logic             done;

  // Environment side: drives the strobes and consumes the phase stream
  modport master (
    output start, num_samples, coarse_in, coarse_rdy, fine_in, fine_rdy, smp_in_vld,
    input  rot_phase, rot_phase_vld, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, num_samples, coarse_in, coarse_rdy, fine_in, fine_rdy, smp_in_vld,
    output rot_phase, rot_phase_vld, busy, done
  );
endinterface

// File: rtl/cfo_phase_sequencer.sv
// Frame controller for carrier-frequency-offset compensation. Walks a wrapped
// 3.13 phase accumulator one step per received sample and emits each phase to
// the derotator; a fine correction can retune the step mid-frame.
module cfo_phase_sequencer #(
  parameter int                 CNT_W  = 12,
  parameter logic signed [15:0] PI     = 16'sh648B,
  parameter logic signed [16:0] TWO_PI = 17'sh0C916
) (
  input  logic                    clk,
  input  logic                    rst,
  cfo_phase_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_CO = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic signed [15:0] r_acc;
  logic signed [15:0] w_acc_next;
  logic signed [15:0] r_inc;
  logic signed [15:0] w_inc_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   w_len_next;
  logic [15:0]        r_rot_phase;
  logic [15:0]        w_rot_phase_next;
  logic               r_rot_phase_vld;
  logic               w_rot_phase_vld_next;
  logic               r_done;
  logic               w_done_next;

  logic [CNT_W-1:0]   w_len_start;
  logic               w_last;
  logic signed [16:0] w_acc_sum;
  logic signed [16:0] w_inc_sum;

  // Operands are both within [-PI, PI] (or one is a raw 16-bit correction),
  // so a single +/- 2*PI correction always lands back in range.
  function automatic logic signed [15:0] wrap_phase(input logic signed [16:0] x);
    logic signed [16:0] pi17;
    logic signed [16:0] y;
    pi17 = {PI[15], PI};
    if (x > pi17)
      y = x - TWO_PI;
    else if (x < -pi17)
      y = x + TWO_PI;
    else
      y = x;
    return y[15:0];
  endfunction

  // A coarse step beyond half a turn per sample is meaningless; saturate it.
  function automatic logic signed [15:0] clamp_pi(input logic signed [15:0] x);
    logic signed [15:0] y;
    if (x > PI)
      y = PI;
    else if (x < -PI)
      y = -PI;
    else
      y = x;
    return y;
  endfunction

  // A zero-length request still produces one sample so the frame always terminates.
  assign w_len_start = (bus.num_samples == '0) ? CNT_W'(1) : bus.num_samples;
  assign w_last      = (r_cnt == (r_len - CNT_W'(1)));
  assign w_acc_sum   = {r_acc[15], r_acc} + {r_inc[15], r_inc};
  assign w_inc_sum   = {r_inc[15], r_inc} + {bus.fine_in[15], $signed(bus.fine_in)};

  // Next-state and datapath decisions; start always wins over sample/fine strobes.
  always_comb begin
    w_state_next         = r_state;
    w_acc_next           = r_acc;
    w_inc_next           = r_inc;
    w_cnt_next           = r_cnt;
    w_len_next           = r_len;
    w_rot_phase_next     = r_rot_phase;
    w_rot_phase_vld_next = 1'b0;
    w_done_next          = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_WAIT_CO;
          w_len_next   = w_len_start;
          w_acc_next   = '0;
          w_cnt_next   = '0;
        end
      end
      ST_WAIT_CO: begin
        if (bus.start) begin
          w_len_next = w_len_start;
          w_acc_next = '0;
          w_cnt_next = '0;
        end else if (bus.coarse_rdy) begin
          w_state_next = ST_RUN;
          w_inc_next   = clamp_pi($signed(bus.coarse_in));
          w_acc_next   = '0;
          w_cnt_next   = '0;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          w_state_next = ST_WAIT_CO;
          w_len_next   = w_len_start;
          w_acc_next   = '0;
          w_cnt_next   = '0;
        end else begin
          // Accumulation uses r_inc, so a same-cycle fine update applies next sample
          if (bus.smp_in_vld) begin
            w_rot_phase_next     = r_acc;
            w_rot_phase_vld_next = 1'b1;
            w_acc_next           = wrap_phase(w_acc_sum);
            w_cnt_next           = r_cnt + CNT_W'(1);
            if (w_last) begin
              w_state_next = ST_IDLE;
              w_done_next  = 1'b1;
            end
          end
          if (bus.fine_rdy)
            w_inc_next = wrap_phase(w_inc_sum);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_acc           <= '0;
      r_inc           <= '0;
      r_cnt           <= '0;
      r_len           <= '0;
      r_rot_phase     <= '0;
      r_rot_phase_vld <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_acc           <= w_acc_next;
      r_inc           <= w_inc_next;
      r_cnt           <= w_cnt_next;
      r_len           <= w_len_next;
      r_rot_phase     <= w_rot_phase_next;
      r_rot_phase_vld <= w_rot_phase_vld_next;
      r_done          <= w_done_next;
    end
  end

  // busy stays up through the done cycle so it drops after the last phase is out
  assign bus.busy          = (r_state != ST_IDLE) || r_done;
  assign bus.rot_phase     = r_rot_phase;
  assign bus.rot_phase_vld = r_rot_phase_vld;
  assign bus.done          = r_done;

endmodule

// File: doc/cfo_phase_sequencer.md
Name: cfo_phase_sequencer

Overview:
Frame-level controller for carrier-frequency-offset compensation in the OFDM receiver.
- Waits for the per-sample coarse phase offset (format 3.13) from the offset estimator, then walks a wrapped phase accumulator one step per received sample.
- Each step emits a rotation phase to the downstream CORDIC derotator.
- Accepts a later fine-offset correction from the long-preamble estimator and folds it into the step mid-frame.
- Terminates the frame after a programmed sample count.

Parameters:
PI, 16'h648B, pi in format 3.13 (25739)
TWO_PI, 17'h0C916, 2*pi in format 3.13 (51478)
CNT_W, 12, width of sample counter / frame length

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
start  in  1  frame-start pulse
num_samples  in  CNT_W  samples in frame; sampled on accepted start
coarse_in  in  16  signed coarse phase step per sample, 3.13
coarse_rdy  in  1  coarse_in valid strobe
fine_in  in  16  signed fine step correction, 3.13
fine_rdy  in  1  fine_in valid strobe
smp_in_vld  in  1  one received sample enters derotator this cycle
rot_phase  out  16  signed rotation phase, 3.13, within [-PI, PI]
rot_phase_vld  out  1  rot_phase valid, one-cycle pulse per sample
busy  out  1  high in WAIT_CO and RUN
done  out  1  one-cycle pulse after last sample of frame

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - rot_phase=0, rot_phase_vld=0, busy=0, done=0.
  - Accumulator acc, step inc, counter cnt and latched length all cleared.
  - Reset has priority over every other input, including mid-frame.
- States: IDLE, WAIT_CO, RUN. busy is high in WAIT_CO and RUN.
- IDLE:
  - start -> WAIT_CO; latch num_samples, with 0 treated as 1.
  - acc=0, cnt=0.
  - All other inputs are ignored.
- WAIT_CO:
  - coarse_rdy -> RUN; inc <= coarse_in (clamped to [-PI, PI]); acc=0.
  - smp_in_vld and fine_rdy are ignored.
  - start re-latches num_samples and stays in WAIT_CO.
- RUN, on each smp_in_vld:
  - rot_phase <= acc; rot_phase_vld=1 on the next cycle. Latency is 1 cycle.
  - acc <= wrap(acc + inc), using inc as it was before this edge.
  - cnt increments.
  - If cnt == len-1, go to IDLE and pulse done in the same cycle as the final rot_phase_vld.
- RUN, on fine_rdy: inc <= wrap(inc + fine_in).
  - If fine_rdy and smp_in_vld occur in the same cycle, the current accumulation uses the old inc.
  - The new inc applies from the next sample.
- RUN, on start: abort the frame.
  - Go to WAIT_CO and re-latch length; acc=0, cnt=0.
  - No done pulse.
  - An smp_in_vld in the same cycle is dropped (no rot_phase_vld).
- Arithmetic:
  - Sums use 17-bit signed arithmetic.
  - wrap(x): if x > PI then x-TWO_PI; else if x < -PI then x+TWO_PI; else x.
  - Because operands are each within [-PI, PI], a single correction suffices; the result truncates to 16 bits.
  - Boundary values exactly +PI and -PI pass unchanged.
- coarse_rdy outside WAIT_CO and fine_rdy outside RUN are ignored.
- rot_phase holds its last value between pulses.

Test Plan:
- Basic frame: start with num_samples=4, coarse_in=0x1000, then 4 smp_in_vld on consecutive cycles -> rot_phase 0x0000, 0x1000, 0x2000, 0x3000, each 1 cycle after its strobe; done coincides with the 4th vld; busy falls the following cycle.
- Wrap: coarse_in=0x4000, num_samples=4 -> rot_phase 0x0000, 0x4000, 0xB6EA (-18710), 0xF6EA (-2326); every output stays within [-PI, PI].
- Fine update: coarse_in=0x1000, fine_rdy with fine_in=0x0100 between the 2nd and 3rd sample -> rot_phase 0x0000, 0x1000, 0x2000, 0x3100.
- Simultaneous fine_rdy and 2nd smp_in_vld, same values as above -> rot_phase 0x0000, 0x1000, 0x2000, 0x3100, because the 2nd accumulation used the old inc.
- Mid-frame reset: rst=0 for 1 cycle after the 2nd sample -> all outputs 0 the next cycle, state IDLE; further smp_in_vld yields no rot_phase_vld; a new frame runs correctly from acc=0.
- Abort and edge cases: start during RUN after 1 sample -> no done, back in WAIT_CO; the subsequent frame restarts at 0. num_samples=0 -> behaves as a 1-sample frame. coarse_rdy arriving in IDLE -> ignored.
